// File: rtl/regs_wb_arbiter_pkg.sv
// Shared register-file types and constants for the writeback / multi-cycle write-port arbiter.
package regs_wb_arbiter_pkg;

   localparam int unsigned REG_ADDR_W    = 5;
   localparam int unsigned REG_W         = 32;
   localparam int unsigned NUM_REGS      = 32;
   localparam int unsigned MC_FIFO_DEPTH = 2;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG     = '0;
   localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
   localparam logic                  WRITE_ENABLE = 1'b1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]      reg_t;

   typedef struct packed {
      reg_addr_t addr;
      reg_t      data;
   } mc_entry_t;

   // A busy source/destination is a hazard unless the FIFO grant is writing it right now.
   function automatic logic reg_hazard(input reg_addr_t            a,
                                       input logic [NUM_REGS-1:0] busy,
                                       input logic                byp_en,
                                       input reg_addr_t           byp_addr);
      return (a != ZERO_REG) && busy[a] && !(byp_en && (byp_addr == a));
   endfunction

endpackage

// File: rtl/regs_wb_arbiter_mc_result_fifo.sv
// mc_result_fifo: synchronous FIFO buffering {addr,data} results from the multi-cycle unit.
module regs_wb_arbiter_mc_result_fifo
   import regs_wb_arbiter_pkg::*;
#(
   parameter  int unsigned DEPTH = MC_FIFO_DEPTH,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  mc_entry_t        data_i,
   input  logic             pop_i,
   output mc_entry_t        head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   mc_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A full FIFO refuses a push even when the head pops in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and buffered multi-cycle results,
// with a busy scoreboard that stalls ID on hazards against outstanding multi-cycle destinations.
module regs_wb_arbiter
   import regs_wb_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = MC_FIFO_DEPTH,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic        clk_100MHz,
   input  logic        arst_n,
   input  logic        wb_w_ena_i,
   input  logic [4:0]  wb_w_addr_i,
   input  logic [31:0] wb_w_data_i,
   input  logic        mc_valid_i,
   input  logic [4:0]  mc_addr_i,
   input  logic [31:0] mc_data_i,
   output logic        mc_ready_o,
   input  logic        mc_issue_i,
   input  logic [4:0]  mc_issue_addr_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic [4:0]  id_rd_addr_i,
   output logic        id_stall_o,
   output logic        hold_wb_o,
   output logic        w_ena_o,
   output logic [4:0]  w_addr_o,
   output logic [31:0] w_data_o
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   mc_entry_t             fifo_in;
   mc_entry_t             fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_cnt;
   logic                  unused_fifo_cnt;
   logic                  push;

   logic                  wb_req;
   logic                  fifo_req;
   logic                  preempt;
   logic                  wb_grant;
   logic                  fifo_grant;

   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;

   assign fifo_in         = '{addr: mc_addr_i, data: mc_data_i};
   assign push            = mc_valid_i && !fifo_full;
   assign unused_fifo_cnt = ^fifo_cnt;

   regs_wb_arbiter_mc_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_mc_result_fifo (
      .clk_i   (clk_100MHz),
      .rst_ni  (arst_n),
      .push_i  (push),
      .data_i  (fifo_in),
      .pop_i   (fifo_grant),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // Write-port grant: WB wins unless the FIFO head has waited MAX_WAIT cycles.
   assign wb_req     = wb_w_ena_i && (wb_w_addr_i != ZERO_REG);
   assign fifo_req   = !fifo_empty;
   assign preempt    = fifo_req && (wait_q == WAIT_W'(MAX_WAIT));
   assign wb_grant   = wb_req && !preempt;
   assign fifo_grant = fifo_req && !wb_grant;

   always_comb begin
      w_ena_o  = 1'b0;
      w_addr_o = ZERO_REG;
      w_data_o = ZERO_WORD;
      if (arst_n) begin
         if (wb_grant) begin
            w_ena_o  = WRITE_ENABLE;
            w_addr_o = wb_w_addr_i;
            w_data_o = wb_w_data_i;
         end else if (fifo_grant) begin
            w_ena_o  = WRITE_ENABLE;
            w_addr_o = fifo_head.addr;
            w_data_o = fifo_head.data;
         end
      end
   end

   assign hold_wb_o  = arst_n && wb_req && preempt;
   assign mc_ready_o = arst_n && !fifo_full;
   assign id_stall_o = arst_n &&
                       (reg_hazard(id_rs1_addr_i, busy_q, fifo_grant, fifo_head.addr) ||
                        reg_hazard(id_rs2_addr_i, busy_q, fifo_grant, fifo_head.addr) ||
                        reg_hazard(id_rd_addr_i,  busy_q, fifo_grant, fifo_head.addr));

   // Head wait counter and busy scoreboard; a same-cycle issue overrides the grant's clear.
   always_comb begin
      wait_d = wait_q;
      busy_d = busy_q;
      if (!fifo_req || fifo_grant) begin
         wait_d = '0;
      end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
         wait_d = wait_q + WAIT_W'(1);
      end
      if (fifo_grant) busy_d[fifo_head.addr] = 1'b0;
      if (mc_issue_i && (mc_issue_addr_i != ZERO_REG)) busy_d[mc_issue_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         wait_q <= '0;
         busy_q <= '0;
      end else begin
         wait_q <= wait_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed self-checking bench for regs_wb_arbiter: WB path, MC path, starvation, hazards,
// full FIFO and reset mid-flight.
module tb_regs_wb_arbiter;

   logic        clk_100MHz = 1'b0;
   logic        arst_n     = 1'b1;
   logic        wb_w_ena_i;
   logic [4:0]  wb_w_addr_i;
   logic [31:0] wb_w_data_i;
   logic        mc_valid_i;
   logic [4:0]  mc_addr_i;
   logic [31:0] mc_data_i;
   logic        mc_ready_o;
   logic        mc_issue_i;
   logic [4:0]  mc_issue_addr_i;
   logic [4:0]  id_rs1_addr_i;
   logic [4:0]  id_rs2_addr_i;
   logic [4:0]  id_rd_addr_i;
   logic        id_stall_o;
   logic        hold_wb_o;
   logic        w_ena_o;
   logic [4:0]  w_addr_o;
   logic [31:0] w_data_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_busy = '0;

   always #5 clk_100MHz = ~clk_100MHz;

   regs_wb_arbiter dut (
      .clk_100MHz      (clk_100MHz),
      .arst_n          (arst_n),
      .wb_w_ena_i      (wb_w_ena_i),
      .wb_w_addr_i     (wb_w_addr_i),
      .wb_w_data_i     (wb_w_data_i),
      .mc_valid_i      (mc_valid_i),
      .mc_addr_i       (mc_addr_i),
      .mc_data_i       (mc_data_i),
      .mc_ready_o      (mc_ready_o),
      .mc_issue_i      (mc_issue_i),
      .mc_issue_addr_i (mc_issue_addr_i),
      .id_rs1_addr_i   (id_rs1_addr_i),
      .id_rs2_addr_i   (id_rs2_addr_i),
      .id_rd_addr_i    (id_rd_addr_i),
      .id_stall_o      (id_stall_o),
      .hold_wb_o       (hold_wb_o),
      .w_ena_o         (w_ena_o),
      .w_addr_o        (w_addr_o),
      .w_data_o        (w_data_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wb_w_ena_i      = 1'b0;
      wb_w_addr_i     = 5'd0;
      wb_w_data_i     = 32'd0;
      mc_valid_i      = 1'b0;
      mc_addr_i       = 5'd0;
      mc_data_i       = 32'd0;
      mc_issue_i      = 1'b0;
      mc_issue_addr_i = 5'd0;
      id_rs1_addr_i   = 5'd0;
      id_rs2_addr_i   = 5'd0;
      id_rd_addr_i    = 5'd0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb_w_ena_i  = 1'b1;
      wb_w_addr_i = a;
      wb_w_data_i = d;
   endtask

   task automatic mc(input logic [4:0] a, input logic [31:0] d);
      mc_valid_i = 1'b1;
      mc_addr_i  = a;
      mc_data_i  = d;
   endtask

   task automatic wport(input string tag, input logic e, input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_ena"},  32'(w_ena_o),  32'(e));
      chk({tag, "_addr"}, 32'(w_addr_o), 32'(a));
      chk({tag, "_data"}, w_data_o,      d);
   endtask

   task automatic nxt();
      @(negedge clk_100MHz);
   endtask

   // Stimulus protocol: no issue to, and no WB write to, a register with an outstanding MC result.
   always @(posedge clk_100MHz) begin
      if (arst_n && mc_issue_i && mc_issue_addr_i != 5'd0) begin
         checks++;
         assert (model_busy[mc_issue_addr_i] === 1'b0) else begin
            errors++;
            $error("FAIL waw_issue observed busy 1 expected 0 reg %0d", mc_issue_addr_i);
         end
      end
      if (arst_n && wb_w_ena_i && wb_w_addr_i != 5'd0) begin
         checks++;
         assert (model_busy[wb_w_addr_i] === 1'b0) else begin
            errors++;
            $error("FAIL waw_wb observed busy 1 expected 0 reg %0d", wb_w_addr_i);
         end
      end
   end

   initial begin
      idle();
      // Reset: outputs forced low even with a live WB request
      #1 arst_n = 1'b0;
      wb(5'd5, 32'h1111_1111);
      #1;
      wport("rst", 1'b0, 5'd0, 32'd0);
      chk("rst_ready", 32'(mc_ready_o), 32'd0);
      chk("rst_hold",  32'(hold_wb_o),  32'd0);
      chk("rst_stall", 32'(id_stall_o), 32'd0);
      nxt(); nxt();
      arst_n = 1'b1;
      idle();
      #1 chk("post_rst_ready", 32'(mc_ready_o), 32'd1);
      wport("post_rst", 1'b0, 5'd0, 32'd0);
      nxt();

      // WB only
      wb(5'd5, 32'hDEAD_BEEF);
      #1 wport("wb5", 1'b1, 5'd5, 32'hDEAD_BEEF);
      chk("wb5_hold", 32'(hold_wb_o), 32'd0);
      nxt();
      wb(5'd0, 32'hDEAD_BEEF);
      #1 wport("wb0", 1'b0, 5'd0, 32'd0);
      nxt();

      // MC result into an idle slot
      idle();
      mc_issue_i = 1'b1; mc_issue_addr_i = 5'd7;
      nxt();
      model_busy[7] = 1'b1;
      idle();
      mc(5'd7, 32'h0000_1234);
      id_rs1_addr_i = 5'd7;
      #1 chk("mc7_stall_pre", 32'(id_stall_o), 32'd1);
      chk("mc7_ready", 32'(mc_ready_o), 32'd1);
      wport("mc7_push", 1'b0, 5'd0, 32'd0);
      nxt();
      mc_valid_i = 1'b0;
      #1 wport("mc7_wr", 1'b1, 5'd7, 32'h0000_1234);
      chk("mc7_bypass", 32'(id_stall_o), 32'd0);
      chk("mc7_ready2", 32'(mc_ready_o), 32'd1);
      nxt();
      model_busy[7] = 1'b0;
      #1 chk("mc7_cleared", 32'(id_stall_o), 32'd0);
      wport("mc7_after", 1'b0, 5'd0, 32'd0);
      nxt();

      // Starvation: head waits MAX_WAIT cycles, then preempts WB
      idle();
      mc_issue_i = 1'b1; mc_issue_addr_i = 5'd9;
      mc(5'd9, 32'h0000_00AA);
      wb(5'd10, 32'h100);
      #1 wport("st_first", 1'b1, 5'd10, 32'h100);
      nxt();
      model_busy[9] = 1'b1;
      mc_issue_i = 1'b0; mc_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb(5'(11 + i), 32'(32'h101 + i));
         #1 wport($sformatf("st_wait%0d", i), 1'b1, 5'(11 + i), 32'(32'h101 + i));
         chk($sformatf("st_hold%0d", i), 32'(hold_wb_o), 32'd0);
         nxt();
      end
      wb(5'd20, 32'h200);
      #1 wport("st_preempt", 1'b1, 5'd9, 32'h0000_00AA);
      chk("st_hold_on", 32'(hold_wb_o), 32'd1);
      nxt();
      model_busy[9] = 1'b0;
      #1 wport("st_wb_after", 1'b1, 5'd20, 32'h200);
      chk("st_hold_off", 32'(hold_wb_o), 32'd0);
      nxt();

      // Hazards on a busy register
      idle();
      mc_issue_i = 1'b1; mc_issue_addr_i = 5'd3;
      nxt();
      model_busy[3] = 1'b1;
      idle();
      id_rs2_addr_i = 5'd3;
      #1 chk("hz_rs2", 32'(id_stall_o), 32'd1);
      id_rs2_addr_i = 5'd0; id_rd_addr_i = 5'd3;
      #1 chk("hz_rd", 32'(id_stall_o), 32'd1);
      id_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd3;
      mc(5'd3, 32'h33);
      #1 chk("hz_push", 32'(id_stall_o), 32'd1);
      nxt();
      mc_valid_i = 1'b0;
      #1 chk("hz_grant", 32'(id_stall_o), 32'd0);
      wport("hz_wr", 1'b1, 5'd3, 32'h33);
      nxt();
      model_busy[3] = 1'b0;
      #1 chk("hz_clear", 32'(id_stall_o), 32'd0);
      nxt();

      // Full FIFO: third result refused in the pop cycle, accepted next
      idle();
      wb(5'd12, 32'hC0);
      mc(5'd13, 32'hD1);
      #1 chk("full_rdy0", 32'(mc_ready_o), 32'd1);
      nxt();
      mc(5'd14, 32'hD2);
      #1 chk("full_rdy1", 32'(mc_ready_o), 32'd1);
      wport("full_wb1", 1'b1, 5'd12, 32'hC0);
      nxt();
      mc_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("full_rdy_w%0d", i), 32'(mc_ready_o), 32'd0);
         nxt();
      end
      mc(5'd15, 32'hD3);
      #1 chk("full_pop_rdy", 32'(mc_ready_o), 32'd0);
      chk("full_pop_hold", 32'(hold_wb_o), 32'd1);
      wport("full_pop", 1'b1, 5'd13, 32'hD1);
      nxt();
      #1 chk("full_accept_rdy", 32'(mc_ready_o), 32'd1);
      wport("full_wb_resume", 1'b1, 5'd12, 32'hC0);
      nxt();
      idle();
      #1 wport("full_d2", 1'b1, 5'd14, 32'hD2);
      chk("full_d2_rdy", 32'(mc_ready_o), 32'd0);
      nxt();
      #1 wport("full_d3", 1'b1, 5'd15, 32'hD3);
      chk("full_d3_rdy", 32'(mc_ready_o), 32'd1);
      nxt();
      #1 wport("full_empty", 1'b0, 5'd0, 32'd0);
      nxt();

      // Reset mid-flight with two buffered results and busy bits
      idle();
      wb(5'd2, 32'hB0);
      mc_issue_i = 1'b1; mc_issue_addr_i = 5'd21;
      mc(5'd21, 32'hE1);
      nxt();
      model_busy[21] = 1'b1;
      mc_issue_addr_i = 5'd22;
      mc(5'd22, 32'hE2);
      nxt();
      model_busy[22] = 1'b1;
      mc_issue_i = 1'b0; mc_valid_i = 1'b0;
      id_rs1_addr_i = 5'd21;
      #1 chk("mr_stall", 32'(id_stall_o), 32'd1);
      chk("mr_ready", 32'(mc_ready_o), 32'd0);
      arst_n = 1'b0;
      #1 wport("mr_in_rst", 1'b0, 5'd0, 32'd0);
      chk("mr_in_rst_stall", 32'(id_stall_o), 32'd0);
      chk("mr_in_rst_rdy",   32'(mc_ready_o), 32'd0);
      #1 arst_n = 1'b1;
      model_busy = '0;
      wb_w_ena_i = 1'b0;
      id_rs2_addr_i = 5'd22;
      #1 chk("mr_busy_gone", 32'(id_stall_o), 32'd0);
      chk("mr_ready_back", 32'(mc_ready_o), 32'd1);
      wport("mr_no_write", 1'b0, 5'd0, 32'd0);
      nxt();
      #1 wport("mr_no_stale", 1'b0, 5'd0, 32'd0);
      chk("mr_busy_gone2", 32'(id_stall_o), 32'd0);
      nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Owns the single write port of the register file and shares it between two writers: pipeline writeback (WB) and a multi-cycle unit (MC, e.g. divider) that returns results out of order with the pipeline.
- Buffers MC results in a small FIFO and keeps a per-register busy scoreboard for outstanding MC destinations.
- Drives stall requests to ID for hazards on busy registers, and to WB when an MC result has been starved too long.
- Sits between WB/MC and the register file write inputs (w_ena/w_addr/w_data).

Parameters:
- FIFO_DEPTH, 2, MC result buffer entries (power of two, >=2)
- MAX_WAIT, 4, cycles an MC result may wait at the FIFO head before it preempts WB (>=1)

Ports:
- clk_100MHz  in  1  system clock
- arst_n  in  1  asynchronous active-low reset
- wb_w_ena_i  in  1  WB write request
- wb_w_addr_i  in  5  WB destination register
- wb_w_data_i  in  32  WB write data
- mc_valid_i  in  1  MC result valid
- mc_addr_i  in  5  MC result destination
- mc_data_i  in  32  MC result data
- mc_ready_o  out  1  FIFO can accept an MC result
- mc_issue_i  in  1  MC operation issued this cycle
- mc_issue_addr_i  in  5  destination of the issued MC operation
- id_rs1_addr_i  in  5  ID source register 1
- id_rs2_addr_i  in  5  ID source register 2
- id_rd_addr_i  in  5  ID destination register
- id_stall_o  out  1  ID must stall (RAW/WAW on a busy register)
- hold_wb_o  out  1  WB write not accepted this cycle; WB holds and re-presents it
- w_ena_o  out  1  register file write enable
- w_addr_o  out  5  register file write address
- w_data_o  out  32  register file write data

Behaviour:
- Reset (arst_n=0, asynchronous) state:
  - FIFO empty, busy[31:1]=0, wait counter=0.
  - All outputs forced to 0 while arst_n=0, including the combinational ones.
  - mc_ready_o=1 from the first cycle after reset release.
- FIFO accept:
  - A push happens when mc_valid_i && mc_ready_o; mc_ready_o = !full (registered count).
  - When full, no push is accepted, even if a pop occurs in the same cycle.
  - A pushed entry is visible at the head the next cycle at the earliest.
- Write-port grant (combinational from current inputs and FIFO head):
  - wb_req = wb_w_ena_i && wb_w_addr_i!=0.
  - fifo_req = FIFO non-empty.
  - preempt = fifo_req && wait_cnt==MAX_WAIT.
  - If wb_req && !preempt: grant WB; w_*_o = wb_*_i.
  - Else if fifo_req: grant the FIFO head; pop on this edge.
  - Else: w_ena_o=0, w_addr_o=0, w_data_o=0.
  - hold_wb_o = wb_req && preempt. WB keeps wb_*_i stable until hold_wb_o=0.
  - A WB write to x0 is never forwarded and never blocks the FIFO.
- Wait counter:
  - Clears when the FIFO is empty or the head is granted.
  - Otherwise increments, saturating at MAX_WAIT.
  - Worst-case MC result latency from reaching the head: MAX_WAIT+1 cycles.
- Scoreboard:
  - mc_issue_i with addr!=0 sets busy[addr].
  - A FIFO-head grant clears busy[head addr].
  - If set and clear hit the same register in the same cycle, set wins.
  - Issue to x0 is ignored.
- ID stall:
  - id_stall_o = 1 if any nonzero rs1/rs2/rd has busy=1, except where that register is being written by the FIFO grant this cycle. The regfile bypass supplies the data, so no stall is raised for it.
  - WAW through rd guarantees no second issue to a busy register and no WB write to a busy register. A bench assertion checks both.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, pointers wrap modulo FIFO_DEPTH.
  - Push into an empty FIFO while WB is granted: the entry waits; the counter starts the next cycle.
- Reset mid-operation: FIFO contents and busy bits are discarded; no write is emitted for them.

Decomposition:
- Shared defines used: REG_ADDR, REG, ZERO_REG, ZERO_WORD, WRITE_ENABLE.
- New shared define: MC_FIFO_DEPTH default.
- Sub-module: mc_result_fifo (sync FIFO, 37-bit entries {addr,data}, push/pop/full/empty/count, async active-low reset).
- Scoreboard, counter and grant logic stay in regs_wb_arbiter.

Test Plan:
- WB only: wb_w_ena_i=1, addr=5, data=0xDEADBEEF, FIFO empty -> w_ena_o=1, w_addr_o=5, w_data_o=0xDEADBEEF same cycle; hold_wb_o=0; addr=0 -> w_ena_o=0.
- MC in idle slot: issue rd=7 (busy[7]=1), push {7,0x1234} with WB idle -> written the next cycle, busy[7] cleared after that edge, mc_ready_o stays 1.
- Starvation: FIFO holds {9,0xAA} and WB writes every cycle -> head waits 4 cycles, 5th cycle hold_wb_o=1 with w_addr_o=9, w_data_o=0xAA; the WB value is written the following cycle.
- Hazard: busy[3]=1, id_rs2_addr_i=3 -> id_stall_o=1. In the cycle the FIFO head {3,x} is granted -> id_stall_o=0. id_rd_addr_i=3 while busy -> id_stall_o=1.
- Full FIFO: two pushes while WB is saturated -> mc_ready_o=0; a third mc_valid_i with a pop in the same cycle is not accepted; accepted the next cycle.
- Reset mid-flight: FIFO holding 2 entries, busy bits set, arst_n pulsed low between edges -> outputs 0 immediately; after release FIFO empty, busy=0, no stale write.
